// File: rtl/mac_job_engine.sv
// MAC job engine: accepts {base, count, clear} jobs, streams operand pairs from memory,
// multiply-accumulates them into a retained 64-bit accumulator and returns the result.
module mac_job_engine #(
  parameter int ADDR_W = 21,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [CNT_W-1:0]  req_count,
  input  logic              req_clear,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_op1,
  input  logic [31:0]       mem_op2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_acc,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_r;
  logic              req_ready_r;
  logic              mem_rd_en_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  remain_r;
  logic              rsp_valid_r;
  logic [63:0]       rsp_acc_r;
  logic              busy_r;
  logic              op_vld_r;
  logic              prod_vld_r;
  logic [63:0]       prod_r;
  logic [63:0]       acc_r;
  logic              accept_s;
  logic              clear_s;
  logic              pipe_empty_s;

  // Accept qualification and pipeline-empty detection
  always_comb begin
    accept_s     = req_valid && req_ready_r;
    clear_s      = accept_s && req_clear;
    pipe_empty_s = !op_vld_r && !prod_vld_r;
  end

  // Job sequencing FSM with registered interface outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      req_ready_r <= 1'b0;
      mem_rd_en_r <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      remain_r    <= CNT_ZERO;
      rsp_valid_r <= 1'b0;
      rsp_acc_r   <= 64'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (req_count == CNT_ZERO) begin
              state_r <= S_RESP;
            end else begin
              state_r     <= S_RUN;
              mem_rd_en_r <= 1'b1;
              addr_r      <= req_base;
              remain_r    <= req_count - CNT_ONE;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        S_RUN: begin
          if (remain_r == CNT_ZERO) begin
            mem_rd_en_r <= 1'b0;
            state_r     <= S_DRAIN;
          end else begin
            addr_r   <= addr_r + ADDR_ONE;
            remain_r <= remain_r - CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (pipe_empty_s) begin
            state_r     <= S_RESP;
            rsp_valid_r <= 1'b1;
            rsp_acc_r   <= acc_r;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_RESP: begin
          // Zero-count jobs enter here directly and load the result one cycle later
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_acc_r   <= acc_r;
          end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          req_ready_r <= 1'b0;
          mem_rd_en_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Operand -> product -> accumulate pipeline
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_vld_r   <= 1'b0;
      prod_vld_r <= 1'b0;
      prod_r     <= 64'd0;
      acc_r      <= 64'd0;
    end else begin
      op_vld_r   <= mem_rd_en_r;
      prod_vld_r <= op_vld_r;
      if (op_vld_r) begin
        prod_r <= 64'(mem_op1) * 64'(mem_op2);
      end else begin
        prod_r <= prod_r;
      end
      if (clear_s) begin
        acc_r <= 64'd0;
      end else if (prod_vld_r) begin
        acc_r <= acc_r + prod_r;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = addr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_acc   = rsp_acc_r;
  assign busy      = busy_r;

endmodule
